// File: rtl/add_share_arbiter.sv
// ---------------------------------------------------------------------------
// add_share_arbiter
//
// Purpose:
//   Lets NREQ independent operand producers take turns on one W-bit adder.
//   A round-robin arbiter picks one requester and captures its operands.
//   The add then runs over a fixed LAT-cycle execute window. The sum, carry
//   and owning requester ID come back on a valid/ready result port. Only one
//   operation is ever in flight. Every output comes straight from a flop.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req        per-requester request level (bit i = requester i)
//   a_in/b_in  packed operands, requester i uses bits [i*W +: W]
//   gnt        one-hot, one-cycle pulse: that requester's operands were taken
//   busy       high while an operation is executing or its result is pending
//   res_valid  result available
//   res_ready  consumer accepts the result
//   res_data   (A+B) mod 2^W
//   res_carry  carry out of bit W-1
//   res_id     index of the requester that owns the result
// ---------------------------------------------------------------------------
module add_share_arbiter #(
   parameter int W    = 16,
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int LAT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_data,
   output logic              res_carry,
   output logic [IDW-1:0]    res_id
);

   // The execute counter only has to hold LAT-1.
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr, ptr_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [W-1:0]    op_a, op_a_nxt;
   logic [W-1:0]    op_b, op_b_nxt;
   logic [IDW-1:0]  op_id, op_id_nxt;
   logic [NREQ-1:0] gnt_nxt;
   logic            busy_nxt;
   logic            res_valid_nxt;
   logic [W-1:0]    res_data_nxt;
   logic            res_carry_nxt;
   logic [IDW-1:0]  res_id_nxt;

   logic            win_found;
   logic [IDW-1:0]  win_id;
   logic            grant;
   logic [W:0]      sum;
   logic [W-1:0]    a_arr [NREQ];
   logic [W-1:0]    b_arr [NREQ];

   // Unpack the flat operand buses into per-requester arrays.
   // The winner's operands can then be picked with a plain index.
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = a_in[g*W +: W];
      assign b_arr[g] = b_in[g*W +: W];
   end

   // The shared adder is one bit wider than the operands.
   // Its top bit is the carry out. It only ever sees the latched operands,
   // so changes on a_in/b_in during execution cannot reach the result.
   assign sum = {1'b0, op_a} + {1'b0, op_b};

   // Round-robin search starting at ptr and wrapping modulo NREQ.
   // The first requester found in that order wins.
   always_comb begin
      int idx;
      logic [IDW-1:0] idx_l;
      idx       = 0;
      idx_l     = '0;
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_l = IDW'(idx);
         if (!win_found && req[idx_l]) begin
            win_found = 1'b1;
            win_id    = idx_l;
         end
      end
   end

   // Next-state and next-output logic.
   // Arbitration happens in IDLE, and again in RESP on the edge where the
   // consumer takes the result. That second case gives a back-to-back grant
   // without passing through IDLE. The pointer only advances on a grant.
   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      cnt_nxt       = cnt;
      op_a_nxt      = op_a;
      op_b_nxt      = op_b;
      op_id_nxt     = op_id;
      gnt_nxt       = '0;
      busy_nxt      = busy;
      res_valid_nxt = res_valid;
      res_data_nxt  = res_data;
      res_carry_nxt = res_carry;
      res_id_nxt    = res_id;
      grant         = 1'b0;

      case (state)
         IDLE: begin
            if (win_found) begin
               grant = 1'b1;
            end
         end
         EXEC: begin
            if (cnt == '0) begin
               res_data_nxt  = sum[W-1:0];
               res_carry_nxt = sum[W];
               res_id_nxt    = op_id;
               res_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RESP: begin
            if (res_ready) begin
               res_valid_nxt = 1'b0;
               if (win_found) begin
                  grant = 1'b1;
               end else begin
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (grant) begin
         op_a_nxt         = a_arr[win_id];
         op_b_nxt         = b_arr[win_id];
         op_id_nxt        = win_id;
         gnt_nxt[win_id]  = 1'b1;
         busy_nxt         = 1'b1;
         state_nxt        = EXEC;
         cnt_nxt          = CW'(LAT - 1);
         if (int'(win_id) == NREQ - 1) begin
            ptr_nxt = '0;
         end else begin
            ptr_nxt = win_id + 1'b1;
         end
      end
   end

   // State and output registers.
   // Reset throws away any operation in flight, so no result is ever
   // produced for it. It also hands top priority back to requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_id    <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         cnt       <= cnt_nxt;
         op_a      <= op_a_nxt;
         op_b      <= op_b_nxt;
         op_id     <= op_id_nxt;
         gnt       <= gnt_nxt;
         busy      <= busy_nxt;
         res_valid <= res_valid_nxt;
         res_data  <= res_data_nxt;
         res_carry <= res_carry_nxt;
         res_id    <= res_id_nxt;
      end
   end

endmodule

// File: tb/tb_add_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_add_share_arbiter
//
// Directed bench for add_share_arbiter with W=16, NREQ=4, IDW=2, LAT=2.
// Inputs change right after the falling edge. Outputs are sampled at the
// falling edge, half a period away from the rising edge that updates them.
// ---------------------------------------------------------------------------
module tb_add_share_arbiter;

   localparam int W    = 16;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int LAT  = 2;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              res_valid;
   logic              res_ready;
   logic [W-1:0]      res_data;
   logic              res_carry;
   logic [IDW-1:0]    res_id;

   int total;
   int passed;

   add_share_arbiter #(
      .W(W), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .a_in(a_in),
      .b_in(b_in),
      .gnt(gnt),
      .busy(busy),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data(res_data),
      .res_carry(res_carry),
      .res_id(res_id)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stops a runaway simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drives the request vector and the consumer ready.
   task automatic applyStimulus(input logic [NREQ-1:0] r, input logic rdy);
      req       = r;
      res_ready = rdy;
   endtask

   // Sets one requester's operand pair.
   task automatic setOperands(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_in[i*W +: W] = a;
      b_in[i*W +: W] = b;
   endtask

   // Resets the DUT with the inputs quiet. Performs no checks.
   task automatic doReset;
      applyStimulus('0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Checks that every output is zero while reset is held.
   task automatic test_reset;
      applyStimulus('0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      total++; if (gnt !== '0) $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); else passed++;
      total++; if (busy !== 1'b0 || res_valid !== 1'b0) $display("[TB] FAIL reset_flags: got busy=%b valid=%b expected 0/0", busy, res_valid); else passed++;
      total++; if ({res_data, res_carry, res_id} !== '0) $display("[TB] FAIL reset_result: got data=%h carry=%b id=%0d expected 0/0/0", res_data, res_carry, res_id); else passed++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Sends one request to requester 0 and checks the gnt pulse, the LAT timing and the result.
   task automatic test_single;
      setOperands(0, 16'd1, 16'd2);
      applyStimulus(4'b0001, 1'b0);
      @(negedge clk);
      total++; if (gnt !== 4'b0001 || busy !== 1'b1) $display("[TB] FAIL single_gnt: got gnt=%b busy=%b expected 0001/1", gnt, busy); else passed++;
      applyStimulus(4'b0000, 1'b0);
      @(negedge clk);
      total++; if (gnt !== 4'b0000 || res_valid !== 1'b0) $display("[TB] FAIL single_pulse: got gnt=%b valid=%b expected 0000/0", gnt, res_valid); else passed++;
      @(negedge clk);
      total++; if (res_valid !== 1'b1 || res_data !== 16'd3 || res_carry !== 1'b0 || res_id !== 2'd0) $display("[TB] FAIL single_result: got v=%b d=%h c=%b id=%0d expected 1/0003/0/0", res_valid, res_data, res_carry, res_id); else passed++;
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      total++; if (res_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL single_release: got valid=%b busy=%b expected 0/0", res_valid, busy); else passed++;
   endtask

   // Checks carry out and truncated data on requester 2.
   task automatic test_overflow;
      setOperands(2, 16'hFFFF, 16'h0001);
      applyStimulus(4'b0100, 1'b1);
      @(negedge clk);
      total++; if (gnt !== 4'b0100) $display("[TB] FAIL ovf_gnt: got %b expected 0100", gnt); else passed++;
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      @(negedge clk);
      total++; if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_carry !== 1'b1 || res_id !== 2'd2) $display("[TB] FAIL ovf_result: got v=%b d=%h c=%b id=%0d expected 1/0000/1/2", res_valid, res_data, res_carry, res_id); else passed++;
      @(negedge clk);
   endtask

   // Holds all requests high with ready high.
   // Expects grants in order 0,1,2,3,0 spaced LAT+1 cycles apart, each with a matching result.
   task automatic test_fairness;
      logic [NREQ-1:0] expGnt;
      logic [W-1:0]    expData;
      doReset();
      for (int i = 0; i < NREQ; i++) begin
         setOperands(i, W'(16'h1000 * (i + 1)), W'(i));
      end
      applyStimulus(4'b1111, 1'b1);
      for (int k = 0; k < 5; k++) begin
         expGnt  = 4'b0001 << (k % 4);
         expData = W'(16'h1000 * ((k % 4) + 1) + (k % 4));
         @(negedge clk);
         total++; if (gnt !== expGnt) $display("[TB] FAIL rr_gnt%0d: got %b expected %b", k, gnt, expGnt); else passed++;
         if (k == 4) applyStimulus(4'b0000, 1'b1);
         @(negedge clk);
         total++; if (gnt !== 4'b0000) $display("[TB] FAIL rr_spacing%0d: got %b expected 0000", k, gnt); else passed++;
         @(negedge clk);
         total++; if (res_valid !== 1'b1 || res_id !== IDW'(k % 4) || res_data !== expData) $display("[TB] FAIL rr_result%0d: got v=%b id=%0d d=%h expected 1/%0d/%h", k, res_valid, res_id, res_data, k % 4, expData); else passed++;
      end
      @(negedge clk);
      total++; if (busy !== 1'b0 || res_valid !== 1'b0) $display("[TB] FAIL rr_idle: got busy=%b valid=%b expected 0/0", busy, res_valid); else passed++;
   endtask

   // Holds ready low for 5 cycles with requester 1 pending.
   // The result must stay put and no new grant may appear until ready rises.
   task automatic test_backpressure;
      setOperands(1, 16'd5, 16'd7);
      applyStimulus(4'b0010, 1'b0);
      @(negedge clk);
      total++; if (gnt !== 4'b0010) $display("[TB] FAIL bp_first_gnt: got %b expected 0010", gnt); else passed++;
      @(negedge clk);
      @(negedge clk);
      total++; if (res_valid !== 1'b1 || res_data !== 16'd12 || res_id !== 2'd1) $display("[TB] FAIL bp_result: got v=%b d=%h id=%0d expected 1/000c/1", res_valid, res_data, res_id); else passed++;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++; if (res_valid !== 1'b1 || res_data !== 16'd12 || gnt !== 4'b0000 || busy !== 1'b1) $display("[TB] FAIL bp_hold%0d: got v=%b d=%h gnt=%b busy=%b expected 1/000c/0000/1", c, res_valid, res_data, gnt, busy); else passed++;
      end
      applyStimulus(4'b0010, 1'b1);
      @(negedge clk);
      total++; if (gnt !== 4'b0010 || res_valid !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL bp_regrant: got gnt=%b v=%b busy=%b expected 0010/0/1", gnt, res_valid, busy); else passed++;
      applyStimulus(4'b0000, 1'b1);
      repeat (3) @(negedge clk);
   endtask

   // Asserts reset one cycle after a grant.
   // Outputs must clear at once, the dropped operation never completes, and priority returns to requester 0.
   task automatic test_reset_mid_exec;
      for (int i = 0; i < NREQ; i++) setOperands(i, W'(i + 1), W'(i + 1));
      applyStimulus(4'b1111, 1'b0);
      @(negedge clk);
      total++; if (gnt !== 4'b0100) $display("[TB] FAIL rst_pre_gnt: got %b expected 0100", gnt); else passed++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if ({gnt, busy, res_valid, res_data, res_carry, res_id} !== '0) $display("[TB] FAIL rst_async_clear: got gnt=%b busy=%b v=%b d=%h c=%b id=%0d expected all 0", gnt, busy, res_valid, res_data, res_carry, res_id); else passed++;
      @(negedge clk);
      total++; if (res_valid !== 1'b0) $display("[TB] FAIL rst_no_result: got %b expected 0", res_valid); else passed++;
      rst = 1'b0;
      @(negedge clk);
      total++; if (gnt !== 4'b0001 || res_valid !== 1'b0) $display("[TB] FAIL rst_post_gnt: got gnt=%b v=%b expected 0001/0", gnt, res_valid); else passed++;
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      @(negedge clk);
      total++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'd2) $display("[TB] FAIL rst_post_result: got v=%b id=%0d d=%h expected 1/0/0002", res_valid, res_id, res_data); else passed++;
      @(negedge clk);
   endtask

   // Changes requester 1's operands right after its grant.
   // The result must come from the values captured at grant.
   task automatic test_exec_change;
      setOperands(1, 16'h1234, 16'h1111);
      applyStimulus(4'b0010, 1'b0);
      @(negedge clk);
      total++; if (gnt !== 4'b0010) $display("[TB] FAIL chg_gnt: got %b expected 0010", gnt); else passed++;
      setOperands(1, 16'hFFFF, 16'hFFFF);
      applyStimulus(4'b0000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      total++; if (res_valid !== 1'b1 || res_data !== 16'h2345 || res_carry !== 1'b0 || res_id !== 2'd1) $display("[TB] FAIL chg_result: got v=%b d=%h c=%b id=%0d expected 1/2345/0/1", res_valid, res_data, res_carry, res_id); else passed++;
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("[TB] FAIL chg_idle: got busy=%b expected 0", busy); else passed++;
   endtask

   // Runs the scenarios in order and prints the summary.
   initial begin
      total     = 0;
      passed    = 0;
      rst       = 1'b1;
      req       = '0;
      res_ready = 1'b0;
      a_in      = '0;
      b_in      = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_overflow();
      test_fairness();
      test_backpressure();
      test_reset_mid_exec();
      test_exec_change();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
